gpio_control_bank: RTL and testbench
====================================

// Module: gpio_control_bank
// PURPOSE
// - NUM_GPIO pad-control channels behind one serial config chain; successor to the single-pad control block.
// - Fully synchronous to serial_clock: shift/load are enables, not clocks.
// - Shifted-bit counter commits only a complete frame; short/long frames are flagged.
// - Sits between housekeeping (serial master) and a padframe segment.
// PARAMETERS
// - NUM_GPIO       4   channels in bank; TOTAL = NUM_GPIO*PAD_CTRL_BITS (localparam)
// - PAD_CTRL_BITS  13  bits per channel, >=13; bits 13+ shift through but drive nothing
// PORTS
// - serial_clock     in  1      sole clock, posedge
// - reset            in  1      async, active-high
// - gpio_defaults    in  TOTAL  per-channel power-on config, channel k at [k*P +: P]
// - serial_data_in   in  1      chain data in
// - serial_shift     in  1      shift enable
// - serial_load      in  1      commit strobe, 1-cycle
// - serial_capture   in  1      readback capture strobe (used only with GPIO_READBACK_EN)
// - serial_data_out  out 1      registered chain tail
// - load_done        out 1      1-cycle pulse after good commit
// - load_error       out 1      sticky bad-frame flag
// - mgmt_gpio_out/oeb  in  NUM_GPIO  mgmt to pad
// - mgmt_gpio_in       out NUM_GPIO  pad to mgmt
// - user_gpio_out/oeb  in  NUM_GPIO  user to pad
// - user_gpio_in       out NUM_GPIO  pad to user
// - user_power_good    in  1         user domain powered
// - pad_gpio_{holdover,slow_sel,vtrip_sel,inenb,ib_mode_sel,ana_en,ana_sel,ana_pol,outenb,out}  out NUM_GPIO
// - pad_gpio_dm        out 3*NUM_GPIO  channel k at [3k+:3]
// - pad_gpio_in        in  NUM_GPIO
// BEHAVIOUR
// - Per-channel bit map: 0 MGMT_EN, 1 OEB, 2 HLDH, 3 INP_DIS, 4 MOD_SEL, 5 AN_EN, 6 AN_SEL, 7 AN_POL, 8 SLOW, 9 TRIP, 12:10 DM.
// - Reset: sr=0, config regs=gpio_defaults, cnt=0, state IDLE, serial_data_out=0, load_done=0, load_error=0.
// - Shift (serial_shift=1, serial_load=0): sr <= {sr[TOTAL-2:0], serial_data_in}; cnt++ saturating at TOTAL+1.
// - serial_data_out <= sr[TOTAL-1] every posedge (one-cycle tail delay, no negedge flop).
// - States: IDLE -> SHIFT on first shift; SHIFT -> COMMIT on serial_load with cnt==TOTAL; COMMIT -> IDLE next cycle.
// - Good load: config regs <= sr at the load edge; load_done=1 during COMMIT only; load_error cleared; cnt<=0.
// - Bad load (cnt!=TOTAL, incl. load in IDLE): config unchanged; load_error<=1; state IDLE; cnt<=0.
// - serial_load and serial_shift same cycle: load wins, no shift, cnt unaffected before compare.
// - serial_shift during COMMIT: accepted, state -> SHIFT, cnt=1.
// - Reset mid-frame: all state to reset values; partial frame discarded, no error.
// - Pad mux per channel k (combinational): outenb = mgmt_en ? (mgmt_oeb ? cfg_oeb : 0) : user_oeb.
// - out = mgmt_en ? (mgmt_oeb ? (dm[2:1]==2'b01 ? ~dm[0] : mgmt_out) : mgmt_out) : user_out.
// - Other pad_gpio_* = config regs directly.
// - mgmt_gpio_in = pad_gpio_in; user_gpio_in = pad_gpio_in & {NUM_GPIO{user_power_good}}.
// CONFIGURATION
// - GPIO_READBACK_EN defined: serial_capture in IDLE/COMMIT loads sr with packed current config (undefined bits 0), cnt<=0.
//   Capture in SHIFT is ignored. Subsequent shifts stream config out on serial_data_out, MSB channel first.
// - Not defined: serial_capture ignored; sr changes only by shift/reset.
// TESTING
// - Reset, NUM_GPIO=4, gpio_defaults ch0=13'h0403 -> pad_gpio_dm[2:0]=3'b001, outenb[0]=mgmt_oeb?1:0, load_error=0.
// - Shift 52 bits setting ch2 dm=3'b010, MGMT_EN=1, then load -> load_done high 1 cycle; mgmt_oeb=1 gives pad_gpio_out[2]=1.
// - Shift 51 bits, load -> load_error=1, config unchanged, no load_done; next good 52-bit frame clears it.
// - Load and shift asserted together at cnt=52 -> commit taken, no shift; 60 shifts then load -> error (saturated cnt).
// - Assert reset after 20 shifts -> outputs return to gpio_defaults; user_power_good=0 forces user_gpio_in=0.
// - GPIO_READBACK_EN: capture after commit, 52 shifts -> serial_data_out reproduces committed frame one cycle delayed.

Source files
------------

// File: rtl/gpio_control_bank.sv
// Bank of NUM_GPIO pad-control channels loaded through one serial chain clocked by serial_clock.
// Optional macro GPIO_READBACK_EN adds a capture strobe that loads the chain with the live config.

module gpio_pad_lane (
  input  logic [12:0] i_cfg,
  input  logic        i_mgmt_out,
  input  logic        i_mgmt_oeb,
  input  logic        i_user_out,
  input  logic        i_user_oeb,
  output logic        o_outenb,
  output logic        o_out
);
  logic w_mgmt_en, w_cfg_oeb, w_dm_drive;

  assign w_mgmt_en  = i_cfg[0];
  assign w_cfg_oeb  = i_cfg[1];
  // dm[2:1]==01 lets the config itself drive a static level while mgmt holds oeb
  assign w_dm_drive = (i_cfg[12:11] == 2'b01);

  assign o_outenb = w_mgmt_en ? (i_mgmt_oeb ? w_cfg_oeb : 1'b0) : i_user_oeb;
  assign o_out    = w_mgmt_en ? ((i_mgmt_oeb && w_dm_drive) ? ~i_cfg[10] : i_mgmt_out)
                              : i_user_out;
endmodule

module gpio_control_bank #(
  parameter int NUM_GPIO      = 4,
  parameter int PAD_CTRL_BITS = 13
) (
  input  logic                               i_serial_clock,
  input  logic                               i_reset,
  input  logic [NUM_GPIO*PAD_CTRL_BITS-1:0]  i_gpio_defaults,
  input  logic                               i_serial_data_in,
  input  logic                               i_serial_shift,
  input  logic                               i_serial_load,
  input  logic                               i_serial_capture,
  output logic                               o_serial_data_out,
  output logic                               o_load_done,
  output logic                               o_load_error,
  input  logic [NUM_GPIO-1:0]                i_mgmt_gpio_out,
  input  logic [NUM_GPIO-1:0]                i_mgmt_gpio_oeb,
  output logic [NUM_GPIO-1:0]                o_mgmt_gpio_in,
  input  logic [NUM_GPIO-1:0]                i_user_gpio_out,
  input  logic [NUM_GPIO-1:0]                i_user_gpio_oeb,
  output logic [NUM_GPIO-1:0]                o_user_gpio_in,
  input  logic                               i_user_power_good,
  output logic [NUM_GPIO-1:0]                o_pad_gpio_holdover,
  output logic [NUM_GPIO-1:0]                o_pad_gpio_slow_sel,
  output logic [NUM_GPIO-1:0]                o_pad_gpio_vtrip_sel,
  output logic [NUM_GPIO-1:0]                o_pad_gpio_inenb,
  output logic [NUM_GPIO-1:0]                o_pad_gpio_ib_mode_sel,
  output logic [NUM_GPIO-1:0]                o_pad_gpio_ana_en,
  output logic [NUM_GPIO-1:0]                o_pad_gpio_ana_sel,
  output logic [NUM_GPIO-1:0]                o_pad_gpio_ana_pol,
  output logic [NUM_GPIO-1:0]                o_pad_gpio_outenb,
  output logic [NUM_GPIO-1:0]                o_pad_gpio_out,
  output logic [3*NUM_GPIO-1:0]              o_pad_gpio_dm,
  input  logic [NUM_GPIO-1:0]                i_pad_gpio_in
);
  localparam int TOTAL = NUM_GPIO * PAD_CTRL_BITS;
  localparam int CW    = $clog2(TOTAL + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(TOTAL);
  localparam logic [CW-1:0] CNT_SAT  = CW'(TOTAL + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [TOTAL-1:0] r_sr, r_cfg;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_state;
  logic             r_sdo, r_load_error;
  logic             w_good_load, w_capture;
  logic [TOTAL-1:0] w_readback;

  assign w_good_load = (r_state == S_SHIFT) && (r_cnt == CNT_FULL);

`ifdef GPIO_READBACK_EN
  // Only the 13 defined bits of each channel are reported; extra bits read as 0
  always_comb begin
    w_readback = '0;
    for (int k = 0; k < NUM_GPIO; k++)
      w_readback[k*PAD_CTRL_BITS +: 13] = r_cfg[k*PAD_CTRL_BITS +: 13];
  end
  assign w_capture = i_serial_capture && (r_state != S_SHIFT);
`else
  logic w_unused_capture;
  assign w_unused_capture = i_serial_capture;
  assign w_readback       = '0;
  assign w_capture        = 1'b0;
`endif

  always_ff @(posedge i_serial_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sr         <= '0;
      r_cfg        <= i_gpio_defaults;
      r_cnt        <= '0;
      r_state      <= S_IDLE;
      r_sdo        <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_sdo <= r_sr[TOTAL-1];
      if (i_serial_load) begin
        // load has priority over a same-cycle shift; the count is judged as it stood
        r_cnt <= '0;
        if (w_good_load) begin
          r_cfg        <= r_sr;
          r_state      <= S_COMMIT;
          r_load_error <= 1'b0;
        end else begin
          r_state      <= S_IDLE;
          r_load_error <= 1'b1;
        end
      end else if (i_serial_shift) begin
        r_sr    <= {r_sr[TOTAL-2:0], i_serial_data_in};
        r_state <= S_SHIFT;
        if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
      end else begin
        if (w_capture) begin
          r_sr  <= w_readback;
          r_cnt <= '0;
        end
        if (r_state == S_COMMIT) r_state <= S_IDLE;
      end
    end
  end

  assign o_serial_data_out = r_sdo;
  assign o_load_done       = (r_state == S_COMMIT);
  assign o_load_error      = r_load_error;

  assign o_mgmt_gpio_in = i_pad_gpio_in;
  assign o_user_gpio_in = i_pad_gpio_in & {NUM_GPIO{i_user_power_good}};

  for (genvar k = 0; k < NUM_GPIO; k++) begin : g_lane
    logic [12:0] w_c;
    assign w_c = r_cfg[k*PAD_CTRL_BITS +: 13];

    assign o_pad_gpio_holdover[k]    = w_c[2];
    assign o_pad_gpio_inenb[k]       = w_c[3];
    assign o_pad_gpio_ib_mode_sel[k] = w_c[4];
    assign o_pad_gpio_ana_en[k]      = w_c[5];
    assign o_pad_gpio_ana_sel[k]     = w_c[6];
    assign o_pad_gpio_ana_pol[k]     = w_c[7];
    assign o_pad_gpio_slow_sel[k]    = w_c[8];
    assign o_pad_gpio_vtrip_sel[k]   = w_c[9];
    assign o_pad_gpio_dm[3*k +: 3]   = w_c[12:10];

    gpio_pad_lane u_lane (
      .i_cfg      (w_c),
      .i_mgmt_out (i_mgmt_gpio_out[k]),
      .i_mgmt_oeb (i_mgmt_gpio_oeb[k]),
      .i_user_out (i_user_gpio_out[k]),
      .i_user_oeb (i_user_gpio_oeb[k]),
      .o_outenb   (o_pad_gpio_outenb[k]),
      .o_out      (o_pad_gpio_out[k])
    );
  end
endmodule

// File: tb/tb_gpio_control_bank.sv
// Directed bench for gpio_control_bank (4 channels x 13 bits), hand-computed expectations.
// Build with GPIO_READBACK_EN defined to exercise the capture/readback path.

module tb_gpio_control_bank;
  localparam int N = 4;
  localparam int P = 13;
  localparam int T = N * P;

  logic           clk = 1'b0;
  logic           rst;
  logic [T-1:0]   defaults;
  logic           sdi, shift, load, capture;
  logic           sdo, load_done, load_error;
  logic [N-1:0]   mgmt_out, mgmt_oeb, mgmt_in, user_out, user_oeb, user_in;
  logic           upg;
  logic [N-1:0]   hold, slow, vtrip, inenb, ibmode, ana_en, ana_sel, ana_pol, outenb, pout;
  logic [3*N-1:0] dm;
  logic [N-1:0]   pad_in;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  gpio_control_bank #(.NUM_GPIO(N), .PAD_CTRL_BITS(P)) dut (
    .i_serial_clock(clk), .i_reset(rst), .i_gpio_defaults(defaults),
    .i_serial_data_in(sdi), .i_serial_shift(shift), .i_serial_load(load),
    .i_serial_capture(capture), .o_serial_data_out(sdo),
    .o_load_done(load_done), .o_load_error(load_error),
    .i_mgmt_gpio_out(mgmt_out), .i_mgmt_gpio_oeb(mgmt_oeb), .o_mgmt_gpio_in(mgmt_in),
    .i_user_gpio_out(user_out), .i_user_gpio_oeb(user_oeb), .o_user_gpio_in(user_in),
    .i_user_power_good(upg),
    .o_pad_gpio_holdover(hold), .o_pad_gpio_slow_sel(slow), .o_pad_gpio_vtrip_sel(vtrip),
    .o_pad_gpio_inenb(inenb), .o_pad_gpio_ib_mode_sel(ibmode), .o_pad_gpio_ana_en(ana_en),
    .o_pad_gpio_ana_sel(ana_sel), .o_pad_gpio_ana_pol(ana_pol),
    .o_pad_gpio_outenb(outenb), .o_pad_gpio_out(pout), .o_pad_gpio_dm(dm),
    .i_pad_gpio_in(pad_in)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Shifts n bits of f MSB first; returns what appeared on serial_data_out after each edge.
  task automatic shift_bits(input logic [T-1:0] f, input int n, output logic [T-1:0] so);
    so = '0;
    for (int i = 0; i < n; i++) begin
      sdi   = (i < T) ? f[T-1-i] : 1'b0;
      shift = 1'b1;
      @(posedge clk); #1;
      if (i < T) so[T-1-i] = sdo;
    end
    shift = 1'b0;
    sdi   = 1'b0;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  logic [T-1:0] fa, fb, fc, so, rb_exp;

  initial begin
    defaults = {13'h0000, 13'h0000, 13'h0000, 13'h0403};
    fa = {13'h0000, 13'h0801, 13'h03FC, 13'h0403};
    fb = {13'h1C03, 13'h0000, 13'h0000, 13'h0000};
    fc = {13'h1000, 13'h0000, 13'h0000, 13'h0403};
    rst = 1'b1; sdi = 0; shift = 0; load = 0; capture = 0;
    mgmt_out = 4'b0000; mgmt_oeb = 4'b0000;
    user_out = 4'b1010; user_oeb = 4'b0110;
    upg = 1'b1; pad_in = 4'b1011;

    repeat (2) @(posedge clk); #1;
    chk("rst_dm",         dm, 12'h001);
    chk("rst_outenb_m0",  outenb, 4'b0110);
    chk("rst_load_error", load_error, 1'b0);
    chk("rst_load_done",  load_done, 1'b0);
    chk("rst_sdo",        sdo, 1'b0);
    mgmt_oeb = 4'b1111; #1;
    chk("rst_outenb_m1",  outenb, 4'b0111);
    chk("rst_out",        pout, 4'b1010);
    rst = 1'b0;

    // good frame A
    shift_bits(fa, T, so);
    pulse_load();
    chk("a_done",    load_done, 1'b1);
    chk("a_dm",      dm, 12'h081);
    chk("a_outenb",  outenb, 4'b0011);
    chk("a_out",     pout, 4'b1110);
    chk("a_hold",    hold, 4'b0010);
    chk("a_anapol",  ana_pol, 4'b0010);
    chk("a_vtrip",   vtrip, 4'b0010);
    chk("a_err",     load_error, 1'b0);
    @(posedge clk); #1;
    chk("a_done_end", load_done, 1'b0);

    // short frame B, then full frame B
    shift_bits(fb, T - 1, so);
    pulse_load();
    chk("short_err",  load_error, 1'b1);
    chk("short_done", load_done, 1'b0);
    chk("short_dm",   dm, 12'h081);
    shift_bits(fb, T, so);
    pulse_load();
    chk("b_done",   load_done, 1'b1);
    chk("b_err",    load_error, 1'b0);
    chk("b_dm",     dm, 12'hE00);
    chk("b_outenb", outenb, 4'b1110);
    chk("b_out",    pout, 4'b0010);
    @(posedge clk); #1;

    // load and shift together at a full count: commit wins, chain not shifted
    shift_bits(fc, T, so);
    load = 1'b1; shift = 1'b1; sdi = 1'b0;
    @(posedge clk); #1;
    load = 1'b0; shift = 1'b0;
    chk("ls_done", load_done, 1'b1);
    chk("ls_dm",   dm, 12'h801);
    @(posedge clk); #1;
    chk("ls_noshift_sdo", sdo, 1'b1);

    // long frame saturates the counter and is rejected
    shift_bits('0, 60, so);
    pulse_load();
    chk("long_err",  load_error, 1'b1);
    chk("long_done", load_done, 1'b0);
    chk("long_dm",   dm, 12'h801);

    // capture in IDLE: readback streams the live config, otherwise ignored
`ifdef GPIO_READBACK_EN
    rb_exp = fc;
`else
    rb_exp = '0;
`endif
    capture = 1'b1;
    @(posedge clk); #1;
    capture = 1'b0;
    shift_bits('0, T, so);
    chk("capture_stream", so, rb_exp);

    // reset mid-frame
    shift_bits(fa, 20, so);
    rst = 1'b1; #1;
    chk("mrst_dm",  dm, 12'h001);
    chk("mrst_err", load_error, 1'b0);
    chk("mrst_sdo", sdo, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mgmt_in",    mgmt_in, 4'b1011);
    chk("user_in_pg", user_in, 4'b1011);
    upg = 1'b0; #1;
    chk("user_in_nopg", user_in, 4'b0000);
    upg = 1'b1;

    // partial frame was discarded: a full frame commits cleanly
    shift_bits(fa, T, so);
    pulse_load();
    chk("post_rst_done", load_done, 1'b1);
    chk("post_rst_dm",   dm, 12'h081);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
